// File: rtl/program_feeder_pkg.sv
// Shared constants for the program feeder: FSM encoding, default depth
// and the bit positions of the fields inside one 6-bit program entry.
package program_feeder_pkg;

    localparam int DEPTH_DEFAULT = 16;

    // Entry layout: [3:0] nibble for the stack CPU, [5:4] hold count h.
    localparam int ENTRY_W  = 6;
    localparam int NIB_LSB  = 0;
    localparam int NIB_W    = 4;
    localparam int HOLD_LSB = 4;
    localparam int HOLD_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RST_CPU = 2'd1,
        ST_PLAY    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [NIB_W-1:0] entry_nibble(input logic [ENTRY_W-1:0] e);
        return e[NIB_LSB +: NIB_W];
    endfunction

    function automatic logic [HOLD_W-1:0] entry_hold(input logic [ENTRY_W-1:0] e);
        return e[HOLD_LSB +: HOLD_W];
    endfunction

endpackage

// File: rtl/program_feeder_if.sv
// Bus between a controller and the program feeder.
// Handshake: load_en, clear and start are single-cycle strobes sampled on
// the rising clock edge; there is no ready/backpressure, a strobe that the
// feeder cannot act on (busy, or full for load_en) is simply dropped.
interface program_feeder_if #(
    parameter int DEPTH = 16
);
    import program_feeder_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic               load_en;
    logic [ENTRY_W-1:0] load_data;
    logic               clear;
    logic               start;

    logic               cpu_rst;
    logic [NIB_W-1:0]   cpu_inbits;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               done;
    logic               overflow;
    state_t             state;      // debug view of the feeder FSM

    modport master (
        output load_en, load_data, clear, start,
        input  cpu_rst, cpu_inbits, pc, busy, done, overflow, state
    );

    modport slave (
        input  load_en, load_data, clear, start,
        output cpu_rst, cpu_inbits, pc, busy, done, overflow, state
    );

endinterface

// File: rtl/program_feeder_mem.sv
// Program storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the feeder's length register
// decides which entries are reachable.
module feeder_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 6,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_feeder.sv
// Program feeder: stores a short program of nibbles and replays it into a
// stack CPU, first holding the CPU in reset, then driving each nibble for
// h+1 cycles. All outputs come straight from registers.
module program_feeder
    import program_feeder_pkg::*;
#(
    parameter int DEPTH          = DEPTH_DEFAULT,
    parameter int CPU_RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    program_feeder_if.slave  bus
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW  = AW + 1;
    localparam int RCW = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;

    state_t             state_q;
    logic [LW-1:0]      len_q;
    logic [AW-1:0]      pc_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [HOLD_W-1:0]  hold_lim_q;   // h of the entry currently driven
    logic [RCW-1:0]     rcnt_q;
    logic               overflow_q;
    logic               cpu_rst_q;
    logic [NIB_W-1:0]   inbits_q;
    logic               busy_q;
    logic               done_q;

    logic               accepting_d;
    logic               full_d;
    logic               wr_en_d;
    logic               last_entry_d;
    logic [AW-1:0]      rd_addr_d;
    logic [ENTRY_W-1:0] rd_data_d;

    assign accepting_d  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign full_d       = (len_q == LW'(DEPTH));
    assign wr_en_d      = accepting_d && bus.load_en && !full_d;
    assign last_entry_d = ({1'b0, pc_q} == (len_q - LW'(1)));
    // The read port always looks at the entry that will be driven next:
    // entry 0 while the CPU is in reset, entry pc+1 during playback.
    assign rd_addr_d    = (state_q == ST_PLAY) ? (pc_q + AW'(1)) : '0;

    feeder_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en_d),
        .waddr_i (len_q[AW-1:0]),
        .wdata_i (bus.load_data),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data_d)
    );

    // Playback FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            pc_q       <= '0;
            hold_cnt_q <= '0;
            hold_lim_q <= '0;
            rcnt_q     <= '0;
            overflow_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            inbits_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    cpu_rst_q <= 1'b0;
                    inbits_q  <= '0;
                    if (bus.load_en) begin
                        if (full_d) overflow_q <= 1'b1;
                        else        len_q      <= len_q + LW'(1);
                    end else if (bus.clear) begin
                        len_q      <= '0;
                        overflow_q <= 1'b0;
                        done_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (bus.start && (len_q != '0)) begin
                        state_q   <= ST_RST_CPU;
                        pc_q      <= '0;
                        rcnt_q    <= '0;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ST_RST_CPU: begin
                    if (rcnt_q == RCW'(CPU_RST_CYCLES - 1)) begin
                        state_q    <= ST_PLAY;
                        cpu_rst_q  <= 1'b0;
                        inbits_q   <= entry_nibble(rd_data_d);
                        hold_lim_q <= entry_hold(rd_data_d);
                        hold_cnt_q <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + RCW'(1);
                    end
                end
                ST_PLAY: begin
                    if (hold_cnt_q == hold_lim_q) begin
                        if (last_entry_d) begin
                            state_q  <= ST_DONE;
                            inbits_q <= '0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            pc_q       <= pc_q + AW'(1);
                            inbits_q   <= entry_nibble(rd_data_d);
                            hold_lim_q <= entry_hold(rd_data_d);
                            hold_cnt_q <= '0;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_inbits = inbits_q;
    assign bus.pc         = pc_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_program_feeder.sv
// Bench for program_feeder: a list-based program model produces the
// expected per-cycle playback trace, a negedge monitor compares it.
module tb_program_feeder;
  import program_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int CRC   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_feeder_if #(.DEPTH(DEPTH)) bus ();

  program_feeder #(.DEPTH(DEPTH), .CPU_RST_CYCLES(CRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // record = {cpu_rst, busy, done, inbits[3:0], pc[3:0]}
  logic [10:0] exp_q[$];
  logic [5:0]  model_prog[$];
  bit          model_ovf = 0;
  bit          mon_en = 0;
  bit          prev_busy = 0;
  logic [10:0] mon_act, mon_exp;

  function automatic logic [10:0] mk(bit r, bit b, bit d, logic [3:0] n, logic [3:0] p);
    return {r, b, d, n, p};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every playback cycle plus the first cycle after it.
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_busy = 0;
    end else begin
      if (bus.busy || prev_busy) begin
        mon_act = {bus.cpu_rst, bus.busy, bus.done, bus.cpu_inbits, bus.pc};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL playback: unexpected output %0h", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL playback: got %0h expected %0h", mon_act, mon_exp);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_load(input logic [5:0] d);
    if (model_prog.size() < DEPTH) model_prog.push_back(d);
    else model_ovf = 1;
  endtask

  task automatic model_clear();
    model_prog.delete();
    model_ovf = 0;
  endtask

  task automatic push_expected();
    int last;
    for (int i = 0; i < CRC; i++) exp_q.push_back(mk(1, 1, 0, 4'h0, 4'h0));
    foreach (model_prog[i]) begin
      for (int k = 0; k <= int'(model_prog[i][5:4]); k++)
        exp_q.push_back(mk(0, 1, 0, model_prog[i][3:0], 4'(i)));
    end
    last = model_prog.size() - 1;
    exp_q.push_back(mk(0, 0, 1, 4'h0, 4'(last)));
  endtask

  // ---------------- drivers (entered and left at posedge+1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] d);
    bus.load_en = 1; bus.load_data = d;
    tick();
    bus.load_en = 0;
    model_load(d);
  endtask

  task automatic do_clear();
    bus.clear = 1;
    tick();
    bus.clear = 0;
    model_clear();
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d records left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Start playback; optionally drive junk strobes while the feeder must ignore them.
  task automatic do_play(input bit noise);
    if (model_prog.size() > 0) push_expected();
    bus.start = 1;
    tick();
    bus.start = 0;
    if (noise) begin
      for (int i = 0; i < CRC + 1; i++) begin
        bus.load_en = 1'($urandom_range(0, 1));
        bus.load_data = 6'($urandom_range(0, 63));
        bus.clear = 1'($urandom_range(0, 1));
        bus.start = 1'($urandom_range(0, 1));
        tick();
      end
      bus.load_en = 0; bus.clear = 0; bus.start = 0;
    end
    wait_drain();
  endtask

  initial begin
    int n, cyc;
    bus.load_en = 0; bus.load_data = '0; bus.clear = 0; bus.start = 0;

    // Reset state, before any clock edge.
    rst = 1;
    #1;
    check("rst_cpu_rst", bus.cpu_rst, 1);
    check("rst_inbits", bus.cpu_inbits, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", bus.state, ST_IDLE);
    tick(); tick();
    @(negedge clk); rst = 0;
    tick();
    check("cpu_rst_release", bus.cpu_rst, 0);
    check("idle_after_rst", bus.state, ST_IDLE);
    mon_en = 1;

    // Basic program: 1, 5 (h=1), 3.
    do_load(6'h01); do_load(6'h15); do_load(6'h03);
    do_play(0);

    // Long hold and replay from DONE.
    do_clear();
    do_load(6'h3A);
    do_play(0);
    check("done_state", bus.state, ST_DONE);
    do_play(0);

    // load_en and start together: load wins, no playback.
    do_clear();
    bus.load_en = 1; bus.load_data = 6'h27; bus.start = 1;
    tick();
    bus.load_en = 0; bus.start = 0;
    model_load(6'h27);
    check("load_start_busy", bus.busy, 0);
    check("load_start_state", bus.state, ST_IDLE);
    do_play(0);

    // Overflow: 17 loads into 16 entries.
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) do_load(6'($urandom_range(0, 63)));
    check("overflow_set", bus.overflow, model_ovf);
    do_play(0);
    check("overflow_sticky", bus.overflow, 1);
    // clear and start together: clear wins.
    bus.clear = 1; bus.start = 1;
    tick();
    bus.clear = 0; bus.start = 0;
    model_clear();
    check("overflow_cleared", bus.overflow, 0);
    check("clear_start_busy", bus.busy, 0);
    check("clear_done", bus.done, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    check("start_empty_ignored", bus.busy, 0);
    tick();
    check("start_empty_state", bus.state, ST_IDLE);

    // Strobes during RST_CPU/PLAY are ignored.
    do_load(6'h12); do_load(6'h04);
    do_play(1);

    // Random programs, sometimes appended to the previous one.
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 2) != 0) do_clear();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) do_load(6'($urandom_range(0, 63)));
      check("rand_overflow", bus.overflow, model_ovf);
      do_play($urandom_range(0, 1) == 1);
    end

    // Reset in the 2nd PLAY cycle aborts immediately.
    do_clear();
    do_load(6'h19); do_load(6'h1C); do_load(6'h0E);
    mon_en = 0;
    bus.start = 1;
    tick();
    bus.start = 0;
    cyc = 0;
    while (bus.state != ST_PLAY && cyc < 20) begin
      tick();
      cyc++;
    end
    check("reach_play", bus.state, ST_PLAY);
    tick();
    rst = 1;
    #1;
    check("abort_cpu_rst", bus.cpu_rst, 1);
    check("abort_inbits", bus.cpu_inbits, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_pc", bus.pc, 0);
    check("abort_state", bus.state, ST_IDLE);
    @(negedge clk); rst = 0;
    model_clear();
    tick();
    check("abort_release_cpu_rst", bus.cpu_rst, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    check("abort_start_ignored", bus.busy, 0);
    check("abort_final_state", bus.state, ST_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_feeder.md
PROGRAM_FEEDER -- requirements
Module: program_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program entries (power of two).
REQ-002 SHALL have parameter CPU_RST_CYCLES, default 2: cycles cpu_rst is held before playback.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_en  input  1  write load_data into the next free program entry.
REQ-006 SHALL have port load_data  input  6  [3:0] nibble for the stack CPU; [5:4] hold count h, nibble driven h+1 cycles.
REQ-007 SHALL have port clear  input  1  discard the loaded program (length := 0).
REQ-008 SHALL have port start  input  1  begin playback of the loaded program.
REQ-009 SHALL have port cpu_rst  output  1  reset driven to the stack CPU.
REQ-010 SHALL have port cpu_inbits  output  4  nibble driven to the stack CPU inbits.
REQ-011 SHALL have port pc  output  log2(DEPTH)  index of the entry being played.
REQ-012 SHALL have port busy  output  1  high in RST_CPU and PLAY.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port overflow  output  1  sticky; a load was attempted while full.

Function
REQ-015 SHALL implement states IDLE, RST_CPU, PLAY, DONE.
REQ-016 In IDLE or DONE, load_en SHALL write entry[length] and increment length; it has priority over start and clear in the same cycle.
REQ-017 At length == DEPTH, load_en SHALL not write, leave length unchanged and set overflow.
REQ-018 clear, with load_en low, in IDLE or DONE SHALL set length := 0 and overflow := 0, then go to IDLE; start in the same cycle is ignored.
REQ-019 start in IDLE or DONE with length > 0, no load_en, no clear, SHALL go to RST_CPU with pc := 0; with length == 0 it SHALL be ignored.
REQ-020 RST_CPU SHALL drive cpu_rst=1 and cpu_inbits=0 for exactly CPU_RST_CYCLES cycles, then go to PLAY.
REQ-021 PLAY SHALL drive cpu_rst=0 and cpu_inbits=entry[pc][3:0] for h+1 cycles (1..4), with h = entry[pc][5:4], then increment pc.
REQ-022 After the last hold cycle of entry length-1, the block SHALL go to DONE; pc SHALL hold length-1.
REQ-023 DONE and IDLE SHALL drive cpu_inbits=0 (NOOP) and cpu_rst=0.
REQ-024 load_en, clear and start SHALL be ignored in RST_CPU and PLAY.
REQ-025 Program contents SHALL persist through playback, so start from DONE replays the same program.
REQ-026 All outputs SHALL be registered; cpu_inbits changes only on clk rising edges.

Reset
REQ-027 rst SHALL asynchronously force IDLE, length=0, pc=0, overflow=0, busy=0, done=0, cpu_inbits=0, cpu_rst=1.
REQ-028 cpu_rst SHALL deassert on the first clk edge after rst falls; rst mid-playback aborts with no further nibbles.
REQ-029 Program memory contents are not reset; length=0 makes them unreachable.

Structure
REQ-030 State encodings, DEPTH default and the 6-bit entry field positions SHALL live in the shared constants include.
REQ-031 The storage array SHALL be the sub-module feeder_mem (1 write port, 1 async read port), not reset.

Verification
REQ-032 Load {0x01 h0, 0x05 h1, 0x03 h0}, start -> cpu_rst high 2 cycles, then cpu_inbits 1,5,5,3, then 0 with done=1.
REQ-033 Load 17 entries with DEPTH=16 -> length 16, overflow=1; clear -> overflow=0, start ignored.
REQ-034 load_en and start in the same IDLE cycle -> entry written, state stays IDLE; start on the next cycle begins playback.
REQ-035 rst asserted in the 2nd PLAY cycle -> cpu_rst=1, cpu_inbits=0 immediately without a clock edge; IDLE after release.
REQ-036 Entry 0x0A with h=3 -> cpu_inbits=0xA for exactly 4 cycles; start in DONE replays an identical sequence.
